// File: rtl/exec_writeback.sv
// exec_writeback: buffers execution results in an in-order FIFO and drains them into the register-file write port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module exec_writeback #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Result_valid,
    input  logic [`DATA_WIDTH-1:0] Execution_Result,
    input  logic [REG_AW-1:0]      res_rd,
    input  logic                   flush,
    output logic                   system_stall,
    output logic                   rf_wr_en,
    output logic [REG_AW-1:0]      rf_wr_addr,
    output logic [`DATA_WIDTH-1:0] rf_wr_data,
    input  logic                   rf_wr_ready,
    input  logic [REG_AW-1:0]      byp_addr,
    output logic                   byp_hit,
    output logic [`DATA_WIDTH-1:0] byp_data,
    output logic                   overflow
);
    logic [REG_AW-1:0]      r_rd   [DEPTH];
    logic [`DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]         r_count;
    logic                   r_stall, r_ovf;
    logic                   w_full, w_valid_res, w_push, w_pop;
    logic [PTR_W:0]         w_count_next;
    logic [PTR_W-1:0]       w_idx;
    logic                   w_byp_hit;
    logic [`DATA_WIDTH-1:0] w_byp_data;

    assign w_full       = r_count == (PTR_W+1)'(DEPTH);
    assign w_valid_res  = Result_valid && res_rd != '0;
    assign w_push       = w_valid_res && !w_full && !flush;
    assign w_pop        = rf_wr_en && rf_wr_ready;
    assign w_count_next = flush ? '0 : r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

    assign rf_wr_en     = r_count != '0;
    assign rf_wr_addr   = r_rd[r_rd_ptr];
    assign rf_wr_data   = r_data[r_rd_ptr];
    assign system_stall = r_stall;
    assign overflow     = r_ovf;
    assign byp_hit      = w_byp_hit;
    assign byp_data     = w_byp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= flush ? '0 : r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= flush ? '0 : r_rd_ptr + PTR_W'(w_pop);
            r_count  <= w_count_next;
            r_stall  <= w_count_next >= (PTR_W+1)'(DEPTH-1);
            r_ovf    <= r_ovf | (w_valid_res && w_full);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wr_ptr]   <= res_rd;
            r_data[r_wr_ptr] <= Execution_Result;
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PTR_W'(k);
            if (byp_addr != '0 && (PTR_W+1)'(k) < r_count && r_rd[w_idx] == byp_addr) begin
                w_byp_hit  = 1'b1;
                w_byp_data = r_data[w_idx];
            end
        end
    end
endmodule
